// File: rtl/seven_segment_reader.sv
// Receive side of a multiplexed 7-segment bus: debounces each scanned digit and decodes it back to a hex word.
// Define SEG_ACTIVE_LOW_EN for common-anode panels (segment lines inverted at the input stage).
module seven_segment_reader #(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg,
    input  logic [N_DIGITS-1:0]   dig_sel,
    input  logic                  clear,
    output logic [4*N_DIGITS-1:0] value,
    output logic [N_DIGITS-1:0]   digit_blank,
    output logic                  frame_valid,
    output logic                  code_err,
    output logic [N_DIGITS-1:0]   err_digit
);
    // state | meaning
    // IDLE  | select not one-hot; nothing being counted
    // COUNT | counting consecutive identical samples of one digit
    // HOLD  | current sample committed; wait for it to change
    typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    state_t                state_q;
    logic [7:0]            cnt_q;
    logic [6:0]            seg_in, seg_q, seg_prev_q;
    logic [N_DIGITS-1:0]   sel_q, sel_prev_q;
    logic [4*N_DIGITS-1:0] value_q, value_d;
    logic [N_DIGITS-1:0]   blank_q, blank_d, seen_q, seen_d, err_digit_q, err_digit_d;
    logic                  frame_valid_q, frame_valid_d, code_err_q, code_err_d;
    logic                  same, sel_ok, commit, hit, is_blank;
    logic [3:0]            code;

`ifdef SEG_ACTIVE_LOW_EN
    assign seg_in = ~seg;
`else
    assign seg_in = seg;
`endif

    assign same     = {seg_q, sel_q} == {seg_prev_q, sel_prev_q};
    assign sel_ok   = (sel_q != '0) && ((sel_q & (sel_q - N_DIGITS'(1))) == '0);
    assign is_blank = (seg_q == 7'h00);
    assign commit   = (state_q == COUNT) && sel_ok && same && (cnt_q == CNT_LAST) && !clear;

    always_comb begin
        hit  = 1'b1;
        code = 4'h0;
        case (seg_q)
            7'h7E:   code = 4'h0;
            7'h30:   code = 4'h1;
            7'h6D:   code = 4'h2;
            7'h79:   code = 4'h3;
            7'h33:   code = 4'h4;
            7'h5B:   code = 4'h5;
            7'h5F:   code = 4'h6;
            7'h70:   code = 4'h7;
            7'h7F:   code = 4'h8;
            7'h7B:   code = 4'h9;
            7'h77:   code = 4'hA;
            7'h1F:   code = 4'hB;
            7'h4E:   code = 4'hC;
            7'h3D:   code = 4'hD;
            7'h4F:   code = 4'hE;
            7'h47:   code = 4'hF;
            default: hit  = 1'b0;
        endcase
    end

    // A full seen vector emits the frame pulse and restarts tracking on the following edge.
    always_comb begin
        value_d       = value_q;
        blank_d       = blank_q;
        err_digit_d   = err_digit_q;
        code_err_d    = 1'b0;
        frame_valid_d = &seen_q;
        seen_d        = (&seen_q) ? '0 : seen_q;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (commit && sel_q[i]) begin
                if (hit) begin
                    value_d[4*i +: 4] = code;
                    blank_d[i]        = 1'b0;
                    seen_d[i]         = 1'b1;
                end else if (is_blank) begin
                    blank_d[i]        = 1'b1;
                    seen_d[i]         = 1'b1;
                end
            end
        end
        if (commit && !hit && !is_blank) begin
            code_err_d  = 1'b1;
            err_digit_d = sel_q;
        end
        if (clear) begin
            seen_d        = '0;
            frame_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            seg_q         <= 7'h00;
            sel_q         <= '0;
            seg_prev_q    <= 7'h00;
            sel_prev_q    <= '0;
            value_q       <= '0;
            blank_q       <= '1;
            seen_q        <= '0;
            err_digit_q   <= '0;
            frame_valid_q <= 1'b0;
            code_err_q    <= 1'b0;
        end else begin
            seg_q         <= seg_in;
            sel_q         <= dig_sel;
            seg_prev_q    <= seg_q;
            sel_prev_q    <= sel_q;
            value_q       <= value_d;
            blank_q       <= blank_d;
            seen_q        <= seen_d;
            err_digit_q   <= err_digit_d;
            frame_valid_q <= frame_valid_d;
            code_err_q    <= code_err_d;
            if (clear) begin
                state_q <= IDLE;
                cnt_q   <= 8'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (sel_ok) begin
                            state_q <= COUNT;
                            cnt_q   <= 8'd1;
                        end else begin
                            cnt_q   <= 8'd0;
                        end
                    end
                    COUNT: begin
                        if (!sel_ok) begin
                            state_q <= IDLE;
                            cnt_q   <= 8'd0;
                        end else if (!same) begin
                            cnt_q   <= 8'd1;
                        end else begin
                            cnt_q   <= cnt_q + 8'd1;
                            if (cnt_q == CNT_LAST) state_q <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (!sel_ok) begin
                            state_q <= IDLE;
                            cnt_q   <= 8'd0;
                        end else if (!same) begin
                            state_q <= COUNT;
                            cnt_q   <= 8'd1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= 8'd0;
                    end
                endcase
            end
        end
    end

    assign value       = value_q;
    assign digit_blank = blank_q;
    assign frame_valid = frame_valid_q;
    assign code_err    = code_err_q;
    assign err_digit   = err_digit_q;
endmodule
